// File: rtl/bg_probe_sequencer.sv
// Sequences five collision probes (feet, below, right, left, top-left) through one background ROM port.
// Issues one address per cycle, captures each colour ROM_LAT edges later, then publishes all results with done.
module bg_probe_sequencer #(
  parameter int         ROM_LAT     = 1,
  parameter int         FEET_DX     = 5,
  parameter int         FEET_DY     = 16,
  parameter logic [2:0] WALL_COLOUR = 3'b010
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [7:0]  swimmerX,
  input  logic [6:0]  swimmerY,
  input  logic [8:0]  bY,
  output logic [16:0] rom_addr,
  input  logic [2:0]  rom_q,
  output logic        busy,
  output logic        done,
  output logic [2:0]  colourG,
  output logic [2:0]  colourGD,
  output logic [2:0]  colourGR,
  output logic [2:0]  colourGL,
  output logic [2:0]  colourTop,
  output logic        wallR,
  output logic        wallL,
  output logic        wallD
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, PUBLISH} state_t;

  state_t      state, state_nxt;
  logic        capture_en;
  logic [3:0]  step;
  logic [3:0]  cap_idx;
  logic [7:0]  snap_x;
  logic [6:0]  snap_y;
  logic [8:0]  snap_by;
  logic [2:0]  sh_g, sh_gd, sh_gr, sh_gl;

  // y*160 + x as shift-and-add, no multiplier.
  function automatic logic [16:0] lin_addr(input logic [8:0] y, input logic [8:0] x);
    return 17'({y, 7'b0}) + 17'({y, 5'b0}) + 17'(x);
  endfunction

  function automatic logic [16:0] probe_addr(input logic [7:0] x, input logic [6:0] y,
                                              input logic [8:0] by, input logic [2:0] idx);
    logic [8:0]  yf, yt, xf;
    logic [16:0] g;
    yf = {2'b0, y} + 9'(FEET_DY) + by;
    yt = {2'b0, y} + by;
    xf = {1'b0, x} + 9'(FEET_DX);
    g  = lin_addr(yf, xf);
    case (idx)
      3'd0:    probe_addr = g;
      3'd1:    probe_addr = lin_addr(yf + 9'd1, xf);
      3'd2:    probe_addr = g + 17'd1;
      3'd3:    probe_addr = g - 17'd1;
      default: probe_addr = lin_addr(yt, {1'b0, x});
    endcase
  endfunction

  // step counts edges since the start edge; probe (step-1-ROM_LAT) is on rom_q.
  assign cap_idx = step - 4'(1 + ROM_LAT);

  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    capture_en = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE: begin
        capture_en = 1'b1;
        if (step == 4'd4) state_nxt = DRAIN;
      end
      DRAIN: begin
        capture_en = 1'b1;
        if (step == 4'(4 + ROM_LAT)) state_nxt = PUBLISH;
      end
      PUBLISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      rom_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      step      <= '0;
      snap_x    <= '0;
      snap_y    <= '0;
      snap_by   <= '0;
      sh_g      <= '0;
      sh_gd     <= '0;
      sh_gr     <= '0;
      sh_gl     <= '0;
      colourG   <= '0;
      colourGD  <= '0;
      colourGR  <= '0;
      colourGL  <= '0;
      colourTop <= '0;
      wallR     <= 1'b0;
      wallL     <= 1'b0;
      wallD     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          // Probe 0 comes straight from the live inputs; the snapshot serves the rest.
          snap_x   <= swimmerX;
          snap_y   <= swimmerY;
          snap_by  <= bY;
          busy     <= 1'b1;
          step     <= 4'd1;
          rom_addr <= probe_addr(swimmerX, swimmerY, bY, 3'd0);
        end
        ISSUE: begin
          rom_addr <= probe_addr(snap_x, snap_y, snap_by, step[2:0]);
          step     <= step + 4'd1;
        end
        DRAIN: step <= step + 4'd1;
        PUBLISH: begin
          // Top probe arrives on this same edge, so it bypasses the shadow.
          colourG   <= sh_g;
          colourGD  <= sh_gd;
          colourGR  <= sh_gr;
          colourGL  <= sh_gl;
          colourTop <= rom_q;
          wallR     <= (sh_gr == WALL_COLOUR);
          wallL     <= (sh_gl == WALL_COLOUR);
          wallD     <= (sh_gd == WALL_COLOUR);
          busy      <= 1'b0;
          done      <= 1'b1;
        end
        default: ;
      endcase
      if (capture_en) begin
        case (cap_idx)
          4'd0:    sh_g  <= rom_q;
          4'd1:    sh_gd <= rom_q;
          4'd2:    sh_gr <= rom_q;
          4'd3:    sh_gl <= rom_q;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bg_probe_sequencer.sv
// Bench for bg_probe_sequencer: two instances (ROM_LAT 1 and 2), each with a registered ROM model,
// compared against address and colour values computed arithmetically from the probe definitions.
module tb_bg_probe_sequencer;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        resetn, start, start2;
  logic [7:0]  sx;
  logic [6:0]  sy;
  logic [8:0]  sby;
  wire  [16:0] addr1, addr2;
  logic [2:0]  q1, q2, q2a;
  wire         busy1, busy2, done1, done2;
  wire  [14:0] col1, col2;
  wire  [2:0]  wal1, wal2;

  int          vectors = 0;
  int          miscompares = 0;
  int          rom_mode = 0;
  logic [16:0] wall_addr = '0;

  bg_probe_sequencer #(.ROM_LAT(1)) dut1 (
    .clock(clock), .resetn(resetn), .start(start), .swimmerX(sx), .swimmerY(sy), .bY(sby),
    .rom_addr(addr1), .rom_q(q1), .busy(busy1), .done(done1),
    .colourG(col1[2:0]), .colourGD(col1[5:3]), .colourGR(col1[8:6]), .colourGL(col1[11:9]),
    .colourTop(col1[14:12]), .wallR(wal1[0]), .wallL(wal1[1]), .wallD(wal1[2]));

  bg_probe_sequencer #(.ROM_LAT(2)) dut2 (
    .clock(clock), .resetn(resetn), .start(start2), .swimmerX(sx), .swimmerY(sy), .bY(sby),
    .rom_addr(addr2), .rom_q(q2), .busy(busy2), .done(done2),
    .colourG(col2[2:0]), .colourGD(col2[5:3]), .colourGR(col2[8:6]), .colourGL(col2[11:9]),
    .colourTop(col2[14:12]), .wallR(wal2[0]), .wallL(wal2[1]), .wallD(wal2[2]));

  function automatic logic [2:0] rom_fn(input logic [16:0] a);
    logic [16:0] h;
    h = a ^ (a >> 3) ^ (a >> 7);
    case (rom_mode)
      0:       return a[2:0];
      1:       return (a == wall_addr) ? 3'b010 : 3'b001;
      default: return h[2:0];
    endcase
  endfunction

  always @(posedge clock) begin
    q1  <= rom_fn(addr1);
    q2a <= rom_fn(addr2);
    q2  <= q2a;
  end

  // Probe order: 0 G, 1 GD, 2 GR, 3 GL, 4 Top.
  function automatic int exp_addr(input int x, input int y, input int by, input int idx);
    int yf, yd, yt, g;
    yf = (y + 16 + by) % 512;
    yd = (yf + 1) % 512;
    yt = (y + by) % 512;
    g  = yf * 160 + x + 5;
    case (idx)
      0:       return g;
      1:       return yd * 160 + x + 5;
      2:       return (g + 1) % 131072;
      3:       return (g + 131071) % 131072;
      default: return yt * 160 + x;
    endcase
  endfunction

  function automatic logic [2:0] exp_col(input int x, input int y, input int by, input int idx);
    return rom_fn(17'(exp_addr(x, y, by, idx)));
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic randomize_inputs();
    sx  = 8'($urandom_range(0, 159));
    sy  = 7'($urandom_range(0, 119));
    sby = 9'($urandom_range(0, 511));
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b1; start2 = 1'b1;
    sx = 8'd80; sy = 7'd80; sby = 9'd280;
    tick(); tick(); tick();
    vectors++;
    if ({busy1, busy2, done1, done2} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b want 0000", {busy1, busy2, done1, done2});
    end
    vectors++;
    if ({addr1, addr2, col1, col2, wal1, wal2} !== '0) begin
      miscompares++;
      $display("FAIL reset_data got addr1=%0d addr2=%0d col1=%h col2=%h want all 0", addr1, addr2, col1, col2);
    end
    start = 1'b0; start2 = 1'b0; resetn = 1'b1;
    tick();
    vectors++;
    if ({busy1, busy2} !== 2'b0) begin
      miscompares++;
      $display("FAIL reset_release_busy got %b want 00", {busy1, busy2});
    end
  endtask

  // Full sweep on both instances; inputs are scrambled while busy to exercise the snapshot.
  task automatic run_trace(input int x, input int y, input int by, input string tag);
    int e[5];
    int wi[3] = '{2, 3, 1};
    for (int i = 0; i < 5; i++) e[i] = exp_addr(x, y, by, i);
    sx = 8'(x); sy = 7'(y); sby = 9'(by);
    start = 1'b1; start2 = 1'b1;
    tick();
    start = 1'b0; start2 = 1'b0;
    randomize_inputs();
    for (int k = 0; k <= 8; k++) begin
      int ea;
      if (k > 0) tick();
      ea = e[(k > 4) ? 4 : k];
      vectors++;
      if (addr1 !== 17'(ea)) begin
        miscompares++;
        $display("FAIL %s addr1 E%0d got %0d want %0d", tag, k, addr1, ea);
      end
      vectors++;
      if (addr2 !== 17'(ea)) begin
        miscompares++;
        $display("FAIL %s addr2 E%0d got %0d want %0d", tag, k, addr2, ea);
      end
      vectors++;
      if (done1 !== (k == 6)) begin
        miscompares++;
        $display("FAIL %s done1 E%0d got %b want %b", tag, k, done1, k == 6);
      end
      vectors++;
      if (done2 !== (k == 7)) begin
        miscompares++;
        $display("FAIL %s done2 E%0d got %b want %b", tag, k, done2, k == 7);
      end
      vectors++;
      if (busy1 !== (k < 6)) begin
        miscompares++;
        $display("FAIL %s busy1 E%0d got %b want %b", tag, k, busy1, k < 6);
      end
      vectors++;
      if (busy2 !== (k < 7)) begin
        miscompares++;
        $display("FAIL %s busy2 E%0d got %b want %b", tag, k, busy2, k < 7);
      end
    end
    for (int i = 0; i < 5; i++) begin
      logic [2:0] ec;
      ec = exp_col(x, y, by, i);
      vectors++;
      if (col1[3*i +: 3] !== ec) begin
        miscompares++;
        $display("FAIL %s colour1[%0d] got %0d want %0d", tag, i, col1[3*i +: 3], ec);
      end
      vectors++;
      if (col2[3*i +: 3] !== ec) begin
        miscompares++;
        $display("FAIL %s colour2[%0d] got %0d want %0d", tag, i, col2[3*i +: 3], ec);
      end
    end
    for (int j = 0; j < 3; j++) begin
      logic ew;
      ew = (exp_col(x, y, by, wi[j]) == 3'b010);
      vectors++;
      if (wal1[j] !== ew || wal2[j] !== ew) begin
        miscompares++;
        $display("FAIL %s wall[%0d] got %b/%b want %b", tag, j, wal1[j], wal2[j], ew);
      end
    end
  endtask

  task automatic test_directed();
    rom_mode = 0;
    run_trace(80, 80, 280, "directed");
  endtask

  task automatic test_walls();
    rom_mode = 1; wall_addr = 17'd60246;
    run_trace(80, 80, 280, "wall_right");
    wall_addr = 17'd99999;
    run_trace(80, 80, 280, "wall_clear");
  endtask

  task automatic test_origin();
    rom_mode = 0;
    run_trace(0, 0, 0, "origin");
  endtask

  task automatic test_restart_ignored();
    int e[5];
    int n_done = 0;
    rom_mode = 2;
    for (int i = 0; i < 5; i++) e[i] = exp_addr(37, 50, 100, i);
    sx = 8'd37; sy = 7'd50; sby = 9'd100;
    start = 1'b1; start2 = 1'b1;
    tick();
    start = 1'b0; start2 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) tick();
      if (done1) n_done++;
      vectors++;
      if (done1 !== (k == 6) || done2 !== (k == 7)) begin
        miscompares++;
        $display("FAIL restart done E%0d got %b%b want %b%b", k, done1, done2, k == 6, k == 7);
      end
      if (k <= 5) begin
        vectors++;
        if (addr1 !== 17'(e[(k > 4) ? 4 : k])) begin
          miscompares++;
          $display("FAIL restart addr1 E%0d got %0d want %0d", k, addr1, e[(k > 4) ? 4 : k]);
        end
      end
      if (k == 1) begin start = 1'b1; start2 = 1'b1; sx = 8'd10; end
      if (k == 2) begin start = 1'b0; start2 = 1'b0; end
    end
    vectors++;
    if (n_done != 1) begin
      miscompares++;
      $display("FAIL restart done_count got %0d want 1", n_done);
    end
  endtask

  task automatic test_back_to_back();
    int ea[5], eb[5];
    rom_mode = 2;
    for (int i = 0; i < 5; i++) begin
      ea[i] = exp_addr(120, 30, 400, i);
      eb[i] = exp_addr(7, 119, 511, i);
    end
    sx = 8'd120; sy = 7'd30; sby = 9'd400;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 13; k++) begin
      int exa;
      if (k > 0) tick();
      exa = (k <= 6) ? ea[(k > 4) ? 4 : k] : eb[(k - 7 > 4) ? 4 : k - 7];
      vectors++;
      if (addr1 !== 17'(exa)) begin
        miscompares++;
        $display("FAIL b2b addr1 E%0d got %0d want %0d", k, addr1, exa);
      end
      vectors++;
      if (done1 !== (k == 6 || k == 13) || done2 !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b done E%0d got %b%b want %b0", k, done1, done2, k == 6 || k == 13);
      end
      vectors++;
      if (busy1 !== (k < 6 || (k >= 7 && k < 13))) begin
        miscompares++;
        $display("FAIL b2b busy1 E%0d got %b", k, busy1);
      end
      if (k == 6) begin
        vectors++;
        if (col1[2:0] !== exp_col(120, 30, 400, 0) || col1[14:12] !== exp_col(120, 30, 400, 4)) begin
          miscompares++;
          $display("FAIL b2b first_colours got %h", col1);
        end
        start = 1'b1; sx = 8'd7; sy = 7'd119; sby = 9'd511;
      end
      if (k == 7) begin start = 1'b0; randomize_inputs(); end
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (col1[3*i +: 3] !== exp_col(7, 119, 511, i)) begin
        miscompares++;
        $display("FAIL b2b colour[%0d] got %0d want %0d", i, col1[3*i +: 3], exp_col(7, 119, 511, i));
      end
    end
  endtask

  task automatic test_mid_reset();
    rom_mode = 0;
    sx = 8'd90; sy = 7'd10; sby = 9'd55;
    start = 1'b1; start2 = 1'b1;
    tick();
    start = 1'b0; start2 = 1'b0;
    tick(); tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    vectors++;
    if ({busy1, busy2, done1, done2} !== 4'b0 || {addr1, addr2} !== '0) begin
      miscompares++;
      $display("FAIL midreset ctrl got busy=%b%b done=%b%b addr=%0d/%0d", busy1, busy2, done1, done2, addr1, addr2);
    end
    vectors++;
    if ({col1, col2, wal1, wal2} !== '0) begin
      miscompares++;
      $display("FAIL midreset colours got %h/%h walls %b/%b want 0", col1, col2, wal1, wal2);
    end
    for (int k = 0; k < 9; k++) begin
      tick();
      vectors++;
      if ({busy1, busy2, done1, done2} !== 4'b0) begin
        miscompares++;
        $display("FAIL midreset idle +%0d got %b want 0000", k, {busy1, busy2, done1, done2});
      end
    end
    run_trace(90, 10, 55, "after_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      int x, y, by;
      x = $urandom_range(0, 159);
      y = $urandom_range(0, 119);
      by = $urandom_range(0, 511);
      rom_mode = (n % 3 == 0) ? 1 : 2;
      wall_addr = 17'(exp_addr(x, y, by, $urandom_range(0, 4)));
      run_trace(x, y, by, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_walls();
    test_origin();
    test_restart_ignored();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
